// File: rtl/step_controller.sv
// Steps an external next-state FSM on rotary detents or a periodic auto-tick,
// with a bounded circular LIFO of past states so backward detents can undo steps.
module step_controller #(
  parameter int                   STATE_W     = 4,
  parameter int                   IN_W        = 2,
  parameter int                   PERIOD      = 100000000,
  parameter int                   DEPTH       = 8,
  parameter logic [STATE_W-1:0]   RESET_STATE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         evt,
  input  logic                         evt_dir,
  input  logic                         auto_en,
  input  logic [IN_W-1:0]              inp,
  input  logic [STATE_W-1:0]           next_state,
  output logic [STATE_W-1:0]           curr_state,
  output logic [IN_W-1:0]              y,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt,
  output logic                         step_pulse,
  output logic                         undo_fail
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = $clog2(DEPTH + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [HW-1:0] HIST_FULL = HW'(DEPTH);

  typedef enum logic {IDLE, LOAD} ctl_t;

  ctl_t                ctl_state, ctl_state_nxt;
  logic                evt_q;
  logic                detent;
  logic [TW-1:0]       tick_cnt;
  logic [STATE_W-1:0]  hist_mem [DEPTH];
  logic [PW-1:0]       top;
  logic [PW-1:0]       top_inc, top_dec;

  logic load_y, push, pop, fail, step;

  assign detent = evt & ~evt_q;
  assign step   = push | pop;

  // top is the next write slot; the most recent entry sits one below it
  always_comb begin
    top_inc = (top == PTR_LAST) ? '0 : top + PW'(1);
    top_dec = (top == '0) ? PTR_LAST : top - PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctl_state <= IDLE;
    else        ctl_state <= ctl_state_nxt;
  end

  always_comb begin
    ctl_state_nxt = ctl_state;
    load_y        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    fail          = 1'b0;
    case (ctl_state)
      IDLE: begin
        if (detent) begin
          if (evt_dir) begin
            load_y        = 1'b1;
            ctl_state_nxt = LOAD;
          end else if (hist_cnt != '0) begin
            pop = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (auto_en && tick_cnt == TICK_LAST) begin
          push = 1'b1;
        end
      end
      LOAD: begin
        push          = 1'b1;
        ctl_state_nxt = IDLE;
      end
      default: ctl_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q      <= 1'b1;
      curr_state <= RESET_STATE;
      y          <= '0;
      hist_cnt   <= '0;
      top        <= '0;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
      undo_fail  <= 1'b0;
    end else begin
      evt_q      <= evt;
      step_pulse <= step;
      undo_fail  <= fail;
      if (load_y) y <= inp;
      if (push) begin
        curr_state <= next_state;
        top        <= top_inc;
        if (hist_cnt != HIST_FULL) hist_cnt <= hist_cnt + HW'(1);
      end else if (pop) begin
        curr_state <= hist_mem[top_dec];
        top        <= top_dec;
        hist_cnt   <= hist_cnt - HW'(1);
      end
      // a detent cycle or the LOAD phase freezes the tick count; steps restart it
      if (!auto_en || step)                    tick_cnt <= '0;
      else if (ctl_state == IDLE && !detent)   tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) hist_mem[top] <= curr_state;
  end

endmodule
